softmax_result_writer: RTL

Memory-side writer at the output end of the softmax datapath. It accepts one packed vector of `NUM` results per handshake, buffers up to `FIFO_DEPTH` vectors, and writes them to consecutive words of a single-port RAM from `start_addr` to `end_addr` inclusive. It is the write-side counterpart of the softmax input-fetch path: same word format, same address-range convention, same `init`/`start`/`done` control.

---
 rtl/softmax_pkg.sv | 24 ++
 rtl/softmax_result_writer_if.sv | 33 +++
 rtl/softmax_wr_fifo.sv | 63 ++++++
 rtl/softmax_result_writer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax memory-side blocks: default geometry,
// the writer state encoding and the packed-word width helper.
package softmax_pkg;

    localparam int DATAWIDTH_DEF  = 16;
    localparam int NUM_DEF        = 4;
    localparam int ADDRSIZE_DEF   = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    // Width of one packed memory word, identical on the fetch and write paths.
    localparam int WORD_W = DATAWIDTH_DEF * NUM_DEF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic int word_width(input int dw, input int num);
        return dw * num;
    endfunction

endpackage

// File: rtl/softmax_result_writer_if.sv
// Producer handshake and RAM write bus of the softmax result writer.
//
// Handshake: a vector on outp transfers in every cycle where outp_valid and
// outp_ready are both 1 at the rising edge. outp_ready never depends
// combinationally on outp_valid. On the RAM side a word is written in every
// cycle where we is 1; we can only be 1 while mem_gnt is 1.
interface softmax_result_writer_if
    import softmax_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int NUM       = NUM_DEF,
    parameter int ADDRSIZE  = ADDRSIZE_DEF
);
    logic [DATAWIDTH*NUM-1:0] outp;
    logic                     outp_valid;
    logic                     outp_ready;
    logic                     mem_gnt;
    logic [ADDRSIZE-1:0]      addr;
    logic [DATAWIDTH*NUM-1:0] d;
    logic                     we;

    // Environment side: producer plus RAM arbiter.
    modport master (
        output outp, outp_valid, mem_gnt,
        input  outp_ready, addr, d, we
    );

    // Writer side.
    modport slave (
        input  outp, outp_valid, mem_gnt,
        output outp_ready, addr, d, we
    );
endinterface

// File: rtl/softmax_wr_fifo.sv
// Synchronous FIFO buffering result vectors between accept and RAM write.
// Pointers carry an extra MSB so full/empty wrap is unambiguous; the count
// is kept in a register so that "full" is a pure flop-derived signal.
module softmax_wr_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic [AW:0]  count_q, count_d;
    logic         do_push, do_pop;

    // Status, head word and next pointer/count values.
    always_comb begin
        full    = (count_q == (AW+1)'(DEPTH));
        empty   = (wptr_q == rptr_q);
        dout    = mem[rptr_q[AW-1:0]];
        do_push = push && !full;
        do_pop  = pop && !empty;
        wptr_d  = do_push ? wptr_q + (AW+1)'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + (AW+1)'(1) : rptr_q;
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/softmax_result_writer.sv
// Writes NUM-element result vectors to consecutive RAM words from start_addr
// to end_addr inclusive (wrapping through 0), buffering up to FIFO_DEPTH
// vectors between the producer and the shared RAM write port.
module softmax_result_writer
    import softmax_pkg::*;
#(
    parameter int DATAWIDTH  = DATAWIDTH_DEF,
    parameter int NUM        = NUM_DEF,
    parameter int ADDRSIZE   = ADDRSIZE_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic                start,
    input  logic [ADDRSIZE-1:0] start_addr,
    input  logic [ADDRSIZE-1:0] end_addr,
    softmax_result_writer_if.slave bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          state_dbg
);
    localparam int W = word_width(DATAWIDTH, NUM);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_ACCEPT = ST_ACCEPT;
    localparam logic [1:0] S_DRAIN  = ST_DRAIN;
    localparam logic [1:0] S_DONE   = ST_DONE;

    logic [1:0]          state_q, state_d;
    logic [ADDRSIZE-1:0] acc_ptr_q, acc_ptr_d;
    logic [ADDRSIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRSIZE-1:0] end_q, end_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic         active, ready_w, wr_fire, push, start_go, idle_like;
    logic         fifo_full, fifo_empty;
    logic [W-1:0] fifo_head;

    softmax_wr_fifo #(
        .W     (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (init),
        .push  (push),
        .pop   (wr_fire),
        .din   (bus.outp),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Handshake and RAM-port outputs; only mem_gnt (and the abort inputs,
    // which must suppress a write in their own cycle) reach we combinationally.
    always_comb begin
        active    = (state_q == S_ACCEPT) || (state_q == S_DRAIN);
        idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
        ready_w   = (state_q == S_ACCEPT) && !fifo_full;
        wr_fire   = active && !fifo_empty && bus.mem_gnt && !init && !reset;
        push      = bus.outp_valid && ready_w && !init;
        start_go  = start && idle_like;
    end

    assign bus.outp_ready = ready_w;
    assign bus.we         = wr_fire;
    assign bus.addr       = wr_fire ? wr_ptr_q : '0;
    assign bus.d          = wr_fire ? fifo_head : '0;
    assign busy           = active;
    assign done           = done_q;
    assign err            = err_q;
    assign state_dbg      = state_q;

    // Next state: init aborts everything, otherwise start, accept and write
    // advance their own pointers; the last write moves to DONE.
    always_comb begin
        state_d   = state_q;
        acc_ptr_d = acc_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        end_d     = end_q;
        done_d    = done_q;
        err_d     = err_q;
        if (init) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            if (start_go) begin
                acc_ptr_d = start_addr;
                wr_ptr_d  = start_addr;
                end_d     = end_addr;
                done_d    = 1'b0;
                err_d     = 1'b0;
                state_d   = S_ACCEPT;
            end
            if (push) begin
                if (acc_ptr_q == end_q) begin
                    state_d = S_DRAIN;
                end else begin
                    acc_ptr_d = acc_ptr_q + ADDRSIZE'(1);
                end
            end
            if (wr_fire) begin
                if (wr_ptr_q == end_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    wr_ptr_d = wr_ptr_q + ADDRSIZE'(1);
                end
            end
            if (bus.outp_valid && idle_like) begin
                err_d = 1'b1;
            end
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_ptr_q <= '0;
            wr_ptr_q  <= '0;
            end_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_ptr_q <= acc_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            end_q     <= end_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule
